wave_analyzer: RTL and testbench

Capture-side counterpart to the function generator's waveform engines. It samples an 8-bit ADC word stream at a programmable divided rate and measures the minimum, maximum and period of the incoming periodic waveform. The measurement is a single shot per `start` pulse, with hysteresis on the crossing detector and a timeout for non-periodic input. It sits on the loopback path (DAC → ADC) and is used for self-test and calibration of the generator outputs.

---
 rtl/funcgen_pkg.sv | 18 +
 rtl/sample_tick_gen.sv | 35 +++
 rtl/wave_analyzer.sv | 190 +++++++++++++++++++
 tb/tb_wave_analyzer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/funcgen_pkg.sv
// Shared definitions for the function generator capture and generation paths.
// Holds the analyzer FSM encoding and the common sample/LUT sizing.
package funcgen_pkg;

  localparam int SAMPLE_W_DEF = 8;
  localparam int LUT_LEN      = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AMP   = 3'd1,
    ST_ARM   = 3'd2,
    ST_EDGE1 = 3'd3,
    ST_LOW   = 3'd4,
    ST_HIGH  = 3'd5,
    ST_FIN   = 3'd6
  } wa_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one tick every clk_div+1 cycles, restartable by clr.
// The divisor is latched on clear and on each wrap so a change lands cleanly.
module sample_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [31:0] clk_div,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;

  assign tick = (cnt_q == div_q);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    div_d = div_q;
    if (clr || tick) begin
      cnt_d = '0;
      div_d = clk_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/wave_analyzer.sv
// Single-shot measurement of min, max and period of a sampled periodic waveform,
// using a hysteresis crossing detector and a saturating period counter as timeout.
module wave_analyzer
  import funcgen_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int WINDOW   = LUT_LEN,
  parameter int HYST     = 8,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] adc_in,
  input  logic [31:0]         clk_div,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [SAMPLE_W-1:0] min_out,
  output logic [SAMPLE_W-1:0] max_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic                flat,
  output logic                timeout
);

  localparam int                 CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0]   LAST_SMP = CNT_W'(WINDOW - 1);
  localparam logic [SAMPLE_W-1:0] HYST_S  = SAMPLE_W'(HYST);
  localparam logic [SAMPLE_W:0]  HYST_X   = (SAMPLE_W+1)'(HYST);
  localparam logic [SAMPLE_W:0]  FLAT_LIM = (SAMPLE_W+1)'(2 * HYST);

  wa_state_e state_q, state_d;

  logic [SAMPLE_W-1:0] min_q, min_d, max_q, max_d;
  logic [SAMPLE_W-1:0] lo_th_q, lo_th_d, hi_th_q, hi_th_d;
  logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [SAMPLE_W-1:0] min_out_q, min_out_d, max_out_q, max_out_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                flat_q, flat_d, timeout_q, timeout_d;

  logic                tick, start_acc;
  logic [SAMPLE_W-1:0] amp_min, amp_max, mid, lo_new, hi_new;
  logic [SAMPLE_W:0]   amp_sum, amp_span, hi_sum;
  logic                win_end, is_flat, below, above, per_sat;

  assign start_acc = start && (state_q == ST_IDLE);

  sample_tick_gen u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_acc),
    .clk_div (clk_div),
    .tick    (tick)
  );

  // Amplitude window result including the sample arriving on this tick.
  always_comb begin
    amp_min  = (adc_in < min_q) ? adc_in : min_q;
    amp_max  = (adc_in > max_q) ? adc_in : max_q;
    amp_sum  = {1'b0, amp_min} + {1'b0, amp_max};
    mid      = SAMPLE_W'(amp_sum >> 1);
    amp_span = {1'b0, amp_max} - {1'b0, amp_min};
    hi_sum   = {1'b0, mid} + HYST_X;
    lo_new   = (mid >= HYST_S) ? (mid - HYST_S) : '0;
    hi_new   = hi_sum[SAMPLE_W] ? '1 : hi_sum[SAMPLE_W-1:0];
  end

  assign win_end = tick && (state_q == ST_AMP) && (smp_cnt_q == LAST_SMP);
  assign is_flat = (amp_span < FLAT_LIM);
  assign below   = (adc_in <= lo_th_q);
  assign above   = (adc_in >= hi_th_q);
  assign per_sat = &per_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      max_q     <= '0;
      lo_th_q   <= '0;
      hi_th_q   <= '0;
      smp_cnt_q <= '0;
      per_cnt_q <= '0;
      min_out_q <= '0;
      max_out_q <= '0;
      period_q  <= '0;
      flat_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      lo_th_q   <= lo_th_d;
      hi_th_q   <= hi_th_d;
      smp_cnt_q <= smp_cnt_d;
      per_cnt_q <= per_cnt_d;
      min_out_q <= min_out_d;
      max_out_q <= max_out_d;
      period_q  <= period_d;
      flat_q    <= flat_d;
      timeout_q <= timeout_d;
    end
  end

  // Timeout takes priority over any crossing seen on the same tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_AMP;
      ST_AMP:   if (win_end) state_d = is_flat ? ST_FIN : ST_ARM;
      ST_ARM:   if (tick) begin
                  if (per_sat)    state_d = ST_FIN;
                  else if (below) state_d = ST_EDGE1;
                end
      ST_EDGE1: if (tick) begin
                  if (per_sat)    state_d = ST_FIN;
                  else if (above) state_d = ST_LOW;
                end
      ST_LOW:   if (tick) begin
                  if (per_sat)    state_d = ST_FIN;
                  else if (below) state_d = ST_HIGH;
                end
      ST_HIGH:  if (tick) begin
                  if (per_sat || above) state_d = ST_FIN;
                end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    min_d     = min_q;
    max_d     = max_q;
    lo_th_d   = lo_th_q;
    hi_th_d   = hi_th_q;
    smp_cnt_d = smp_cnt_q;
    per_cnt_d = per_cnt_q;
    min_out_d = min_out_q;
    max_out_d = max_out_q;
    period_d  = period_q;
    flat_d    = flat_q;
    timeout_d = timeout_q;
    if (start_acc) begin
      min_d     = '1;
      max_d     = '0;
      smp_cnt_d = '0;
      per_cnt_d = '0;
      min_out_d = '0;
      max_out_d = '0;
      period_d  = '0;
      flat_d    = 1'b0;
      timeout_d = 1'b0;
    end else if (tick && (state_q == ST_AMP)) begin
      min_d     = amp_min;
      max_d     = amp_max;
      smp_cnt_d = smp_cnt_q + CNT_W'(1);
      if (win_end) begin
        min_out_d = amp_min;
        max_out_d = amp_max;
        lo_th_d   = lo_new;
        hi_th_d   = hi_new;
        per_cnt_d = '0;
        if (is_flat) begin
          flat_d   = 1'b1;
          period_d = '0;
        end
      end
    end else if (tick && (state_q inside {ST_ARM, ST_EDGE1, ST_LOW, ST_HIGH})) begin
      if (per_sat) begin
        timeout_d = 1'b1;
        period_d  = '1;
      end else begin
        per_cnt_d = per_cnt_q + PERIOD_W'(1);
        if (state_q == ST_EDGE1 && above) per_cnt_d = '0;
        if (state_q == ST_HIGH && above)  period_d  = per_cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_FIN);
  end

  assign min_out    = min_out_q;
  assign max_out    = max_out_q;
  assign period_out = period_q;
  assign flat       = flat_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed and randomized measurements of wave_analyzer against a crossing-search model.
module tb_wave_analyzer;
  import funcgen_pkg::*;

  localparam int NS  = 4096;
  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  adc_in = 8'h00;
  logic [31:0] clk_div = 32'd0;
  logic        start_a = 1'b0, start_b = 1'b0;

  logic        busy_a, done_a, flat_a, to_a;
  logic [7:0]  min_a, max_a;
  logic [23:0] per_a;
  logic        busy_b, done_b, flat_b, to_b;
  logic [7:0]  min_b, max_b;
  logic [9:0]  per_b;

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;
  logic [7:0] samp [NS];

  logic        o_busy, o_done, o_flat, o_to;
  logic [7:0]  o_min, o_max;
  logic [23:0] o_per;

  always #5 clk = ~clk;

  wave_analyzer dut_a (
    .clk(clk), .rst_n(rst_n), .adc_in(adc_in), .clk_div(clk_div), .start(start_a),
    .busy(busy_a), .done(done_a), .min_out(min_a), .max_out(max_a),
    .period_out(per_a), .flat(flat_a), .timeout(to_a)
  );

  wave_analyzer #(.PERIOD_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .adc_in(adc_in), .clk_div(clk_div), .start(start_b),
    .busy(busy_b), .done(done_b), .min_out(min_b), .max_out(max_b),
    .period_out(per_b), .flat(flat_b), .timeout(to_b)
  );

  assign o_busy = (sel != 0) ? busy_b : busy_a;
  assign o_done = (sel != 0) ? done_b : done_a;
  assign o_flat = (sel != 0) ? flat_b : flat_a;
  assign o_to   = (sel != 0) ? to_b   : to_a;
  assign o_min  = (sel != 0) ? min_b  : min_a;
  assign o_max  = (sel != 0) ? max_b  : max_a;
  assign o_per  = (sel != 0) ? {14'd0, per_b} : per_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First index >= from whose sample is at/below lo (want_low) or at/above hi.
  function automatic int find(input int from, input bit want_low, input int lo, input int hi);
    for (int n = from; n < NS; n++) begin
      if (want_low ? (int'(samp[n]) <= lo) : (int'(samp[n]) >= hi)) return n;
    end
    return BIG;
  endfunction

  task automatic model(input int pw, output logic [7:0] mn, output logic [7:0] mx,
                       output logic [23:0] per, output logic fl, output logic to,
                       output int term);
    int mid, lo, hi, lim, a, b, c, d;
    mn = 8'hFF; mx = 8'h00;
    for (int n = 0; n < 512; n++) begin
      if (samp[n] < mn) mn = samp[n];
      if (samp[n] > mx) mx = samp[n];
    end
    mid = (int'(mn) + int'(mx)) / 2;
    lo  = (mid - 8 < 0) ? 0 : mid - 8;
    hi  = (mid + 8 > 255) ? 255 : mid + 8;
    lim = (1 << pw) - 1;
    fl = 1'b0; to = 1'b0; per = '0; term = 511;
    if (int'(mx) - int'(mn) < 16) begin
      fl = 1'b1;
      return;
    end
    a = find(512, 1'b1, lo, hi);
    b = (a >= NS) ? BIG : find(a + 1, 1'b0, lo, hi);
    if (b >= 512 + lim) begin
      to = 1'b1; per = 24'(lim); term = 512 + lim;
      return;
    end
    c = find(b + 1, 1'b1, lo, hi);
    d = (c >= NS) ? BIG : find(c + 1, 1'b0, lo, hi);
    if (d >= b + lim + 1) begin
      to = 1'b1; per = 24'(lim); term = b + lim + 1;
      return;
    end
    per = 24'(d - b);
    term = d;
  endtask

  task automatic fill_tri();
    for (int n = 0; n < NS; n++) begin
      int t = n % 512;
      samp[n] = 8'((t < 256) ? t : 511 - t);
    end
  endtask

  task automatic fill_square(input int lo, input int hi, input int p, input int ph, input bit rnd_glitch);
    int mid = (lo + hi) / 2;
    for (int n = 0; n < NS; n++) begin
      int t = (n + ph) % p;
      samp[n] = 8'((t < p / 2) ? lo : hi);
      if (rnd_glitch) begin
        if ($urandom_range(0, 15) == 0) samp[n] = 8'((t < p / 2) ? mid + 5 : mid - 5);
      end else begin
        if (t == p / 5)     samp[n] = 8'(mid + 5);
        if (t == 7 * p / 10) samp[n] = 8'(mid - 5);
      end
    end
  endtask

  // Runs one measurement; sample n is presented for the clk_div+1 cycles ending at its tick.
  task automatic measure(input string name, input int which, input int d_div, input int rep_at,
                         input bit rep_done, input int abort_at, output int done_cyc);
    logic [7:0]  emn, emx;
    logic [23:0] eper;
    logic        efl, eto;
    int term, exp_done, ndone, idx;
    bit busy_ok, busy_after;
    sel = which;
    model((which != 0) ? 10 : 24, emn, emx, eper, efl, eto, term);
    exp_done = (term + 1) * (d_div + 1);
    clk_div = 32'(d_div);
    @(negedge clk);
    if (which != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    done_cyc = -1; ndone = 0; busy_ok = 1'b1; busy_after = 1'b1;
    for (int c = 0; c < exp_done + 20; c++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      idx = c / (d_div + 1);
      adc_in = samp[(idx >= NS) ? NS - 1 : idx];
      if (c == rep_at || (rep_done && c == exp_done)) begin
        if (which != 0) start_b = 1'b1; else start_a = 1'b1;
      end
      if (c == 0)
        check({name, " cleared_on_start"},
              32'(o_min == 8'h00 && o_max == 8'h00 && o_per == 24'h0 && !o_flat && !o_to), 32'd1);
      if (o_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if ((done_cyc < 0 || c == done_cyc) && !o_busy) busy_ok = 1'b0;
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = o_busy;
      if (c == abort_at) break;
      if (done_cyc >= 0 && c == done_cyc + 4) break;
    end
    start_a = 1'b0; start_b = 1'b0;
    if (abort_at >= 0) return;
    check({name, " min_out"},    32'(o_min), 32'(emn));
    check({name, " max_out"},    32'(o_max), 32'(emx));
    check({name, " period_out"}, 32'(o_per), 32'(eper));
    check({name, " flat"},       32'(o_flat), 32'(efl));
    check({name, " timeout"},    32'(o_to), 32'(eto));
    check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, " done_single"}, 32'(ndone), 32'd1);
    check({name, " busy_throughout"}, 32'(busy_ok), 32'd1);
    check({name, " busy_after_done"}, 32'(busy_after), 32'd0);
  endtask

  initial begin
    int dc0, dc3, dummy, ndone;
    // Reset state
    @(negedge clk);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset outputs",
          32'(min_a == 0 && max_a == 0 && per_a == 0 && !flat_a && !to_a), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Triangle, full period 512 samples, with start re-pulsed mid-run and at done
    fill_tri();
    measure("tri_div0", 0, 0, 300, 1'b1, -1, dc0);
    check("tri period 512", 32'(per_a), 32'd512);
    check("tri max ff", 32'(max_a), 32'hFF);
    measure("tri_div3", 0, 3, -1, 1'b0, -1, dc3);
    check("tri 4x done", 32'(dc3 >= 4 * dc0 - 4 && dc3 <= 4 * dc0 + 4), 32'd1);

    // Constant input: flat
    for (int n = 0; n < NS; n++) samp[n] = 8'h80;
    measure("const80", 0, 0, -1, 1'b0, -1, dummy);
    check("const flat", 32'(flat_a), 32'd1);

    // Square with in-band glitches
    fill_square(8'h20, 8'hE0, 100, 0, 1'b0);
    measure("square100", 0, 1, -1, 1'b0, -1, dummy);
    check("square period 100", 32'(per_a), 32'd100);

    // Randomized squares
    for (int k = 0; k < 4; k++) begin
      fill_square(int'($urandom_range(0, 64)), int'($urandom_range(192, 255)),
                  int'($urandom_range(20, 300)), int'($urandom_range(0, 299)), 1'b1);
      measure($sformatf("rsq%0d", k), 0, int'($urandom_range(0, 2)), -1, 1'b0, -1, dummy);
    end

    // Timeout with a 10-bit period counter: triangle window then stuck high
    fill_tri();
    for (int n = 512; n < NS; n++) samp[n] = 8'hFF;
    measure("timeout10", 1, 0, -1, 1'b0, -1, dummy);
    check("timeout period 3ff", 32'(per_b), 32'h3FF);
    sel = 0;

    // Reset while in LOW: abort, outputs zero, no done
    fill_tri();
    measure("reset_low", 0, 0, -1, 1'b0, 750, dummy);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort outputs",
          32'(min_a == 0 && max_a == 0 && per_a == 0 && !flat_a && !to_a), 32'd1);
    ndone = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (done_a) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    check("abort idle", 32'(busy_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
